muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; legal values are 8..64.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port wr_hi  input  1  write wdata into HI.
REQ-009 SHALL have port wr_lo  input  1  write wdata into LO.
REQ-010 SHALL have port wdata  input  WIDTH  data for HI/LO direct writes.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port dz  output  1  divide-by-zero flag, valid while done=1.
REQ-014 SHALL have port hi  output  WIDTH  HI register: product upper half, or remainder.
REQ-015 SHALL have port lo  output  WIDTH  LO register: product lower half, or quotient.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (busy=0) and RUN (busy=1), plus an iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-017 SHALL accept start only in IDLE; the accepting edge latches a, b and op, loads the counter with WIDTH, and moves the FSM to RUN.
REQ-018 SHALL ignore start asserted while busy=1; the operation in flight is unaffected.
REQ-019 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per RUN edge; counter decrements each step.
REQ-020 SHALL, on the WIDTH-th RUN edge, write the result to hi/lo, return to IDLE, and assert done for exactly one cycle; the result is visible WIDTH edges after the accepting edge.
REQ-021 SHALL, for signed ops, operate on magnitudes and apply sign correction within the final edge, adding no extra cycles.
REQ-022 MULT/MULTU SHALL produce the exact 2*WIDTH-bit product: {hi,lo}.
REQ-023 DIV/DIVU SHALL set lo=quotient and hi=remainder; signed quotient truncates toward zero and the remainder takes the sign of a.
REQ-024 DIV of -2^(WIDTH-1) by -1 SHALL give lo=-2^(WIDTH-1) (wrap) and hi=0, with no flag.
REQ-025 Divide with b=0 SHALL take the same latency and give lo=all ones, hi=a, and dz=1 during the done cycle; dz SHALL be 0 at all other times.
REQ-026 wr_hi/wr_lo SHALL take effect only in IDLE with start=0; they are ignored while busy or when start is accepted on the same edge.
REQ-027 wr_hi and wr_lo asserted together SHALL both load wdata.
REQ-028 hi/lo SHALL hold their values between updates; they SHALL NOT show intermediate values during RUN.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, dz=0, hi=0, lo=0 and clear the counter, overriding start and writes.
REQ-030 reset during RUN SHALL abort the operation; no done pulse follows.

Verification (WIDTH=32)
REQ-031 MULTU a=0x00000001, b=0xF0000005 -> done 32 edges after start, hi=0x00000000, lo=0xF0000005, dz=0.
REQ-032 MULT a=0xF0000005, b=0x00000002 -> hi=0xFFFFFFFF, lo=0xE000000A.
REQ-033 DIVU a=0xF0000005, b=0x00000010 -> lo=0x0F000000, hi=0x00000005; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234, dz=1 for one cycle only.
REQ-035 Second start with different operands 5 cycles into RUN -> ignored; result matches the first op; wr_lo during RUN -> lo unchanged.
REQ-036 reset at RUN cycle 10 -> next cycle busy=0, hi=lo=0, and no done pulse; a following start completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle; signed ops run on magnitudes.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   // Operand magnitudes for the accepting edge
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign a_neg = op[0] & a[WIDTH-1];
   assign b_neg = op[0] & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc = {partial remainder, dividend bits / quotient bits}, shifted left each step
   logic [WIDTH:0]     div_shift, div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand_q};
   assign div_next  = div_diff[WIDTH]
                    ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

   logic [2*WIDTH-1:0] acc_step, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign acc_step = is_div_q ? div_next : mul_next;
   assign prod_fix = neg_q  ? -acc_step : acc_step;
   assign quo_fix  = neg_q  ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
   assign rem_fix  = rneg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      a_d      = a_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               cnt_d    = CW'(WIDTH);
               is_div_d = op[1];
               a_d      = a;
               neg_d    = a_neg ^ b_neg;
               rneg_d   = a_neg;
               if (op[1]) begin
                  mcand_d = b_mag;
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
               end else begin
                  mcand_d = a_mag;
                  acc_d   = {{WIDTH{1'b0}}, b_mag};
               end
            end else begin
               if (wr_hi) hi_d = wdata;
               if (wr_lo) lo_d = wdata;
            end
         end
         S_RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (mcand_q == '0) begin
                  // Divide by zero keeps the full latency and returns a fixed pattern
                  dz_d = 1'b1;
                  hi_d = a_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         a_q      <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         a_q      <= a_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign dz   = dz_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit at WIDTH=32: directed vectors plus random ops against an arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b;
   logic         wr_hi, wr_lo;
   logic [W-1:0] wdata;
   logic         busy, done, dz;
   logic [W-1:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] exp_q[$];

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   // Reference result {hi, lo} from plain integer arithmetic
   function automatic logic [2*W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
      longint          sx, sy, sq, sr;
      longint unsigned ux, uy, uq, ur;
      logic [63:0]     p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      if (o[1] && y == 0) return {x, {W{1'b1}}};
      case (o)
         2'b00: p = ux * uy;
         2'b01: p = sx * sy;
         2'b10: begin
            uq = ux / uy;
            ur = ux % uy;
            p  = {ur[31:0], uq[31:0]};
         end
         default: begin
            sq = sx / sy;
            sr = sx % sy;
            p  = {sr[31:0], sq[31:0]};
         end
      endcase
      return p;
   endfunction

   task automatic idle_inputs();
      start = 1'b0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
   endtask

   // Issue one op and wait (bounded) for done; reports latency, results and side observations
   task automatic issue_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output int lat, output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                           output logic r_dz, output logic held, output logic after_ok);
      logic [W-1:0] hi0, lo0;
      @(negedge clock);
      op = o; a = x; b = y; start = 1'b1;
      hi0 = hi; lo0 = lo;
      @(posedge clock); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      lat = -1;
      held = 1'b1;
      for (int n = 1; n <= W + 8; n++) begin
         @(posedge clock); #1;
         if (done) begin
            lat = n;
            break;
         end
         if (hi !== hi0 || lo !== lo0 || busy !== 1'b1 || dz !== 1'b0) held = 1'b0;
      end
      r_hi = hi; r_lo = lo; r_dz = dz;
      @(posedge clock); #1;
      after_ok = (done === 1'b0 && dz === 1'b0 && busy === 1'b0 && hi === r_hi && lo === r_lo);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; wr_hi = 1'b1; wr_lo = 1'b1;
      op = 2'b00; a = 32'd3; b = 32'd5; wdata = 32'hDEAD_BEEF;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy, done, dz} !== 3'b000 || hi !== '0 || lo !== '0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h expected all zero",
                  busy, done, dz, hi, lo);
      end
      reset = 1'b0;
      idle_inputs();
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || hi !== '0) begin
         failures++;
         $display("FAIL reset_release: busy=%b hi=%h expected 0/0", busy, hi);
      end
   endtask

   task automatic test_directed();
      logic [1:0]   t_op[6];
      logic [W-1:0] t_a[6], t_b[6], t_hi[6], t_lo[6];
      logic         t_dz[6];
      int           lat;
      logic [W-1:0] r_hi, r_lo;
      logic         r_dz, held, after_ok;
      t_op[0] = 2'b00; t_a[0] = 32'h0000_0001; t_b[0] = 32'hF000_0005; t_hi[0] = 32'h0000_0000; t_lo[0] = 32'hF000_0005; t_dz[0] = 1'b0;
      t_op[1] = 2'b01; t_a[1] = 32'hF000_0005; t_b[1] = 32'h0000_0002; t_hi[1] = 32'hFFFF_FFFF; t_lo[1] = 32'hE000_000A; t_dz[1] = 1'b0;
      t_op[2] = 2'b10; t_a[2] = 32'hF000_0005; t_b[2] = 32'h0000_0010; t_hi[2] = 32'h0000_0005; t_lo[2] = 32'h0F00_0000; t_dz[2] = 1'b0;
      t_op[3] = 2'b11; t_a[3] = 32'hFFFF_FFF9; t_b[3] = 32'h0000_0002; t_hi[3] = 32'hFFFF_FFFF; t_lo[3] = 32'hFFFF_FFFD; t_dz[3] = 1'b0;
      t_op[4] = 2'b11; t_a[4] = 32'h0000_1234; t_b[4] = 32'h0000_0000; t_hi[4] = 32'h0000_1234; t_lo[4] = 32'hFFFF_FFFF; t_dz[4] = 1'b1;
      t_op[5] = 2'b11; t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF; t_hi[5] = 32'h0000_0000; t_lo[5] = 32'h8000_0000; t_dz[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         issue_op(t_op[i], t_a[i], t_b[i], lat, r_hi, r_lo, r_dz, held, after_ok);
         checks++;
         if (lat != W) begin
            failures++;
            $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, W);
         end
         checks++;
         if (r_hi !== t_hi[i] || r_lo !== t_lo[i] || r_dz !== t_dz[i]) begin
            failures++;
            $display("FAIL directed%0d_result: got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                     i, r_hi, r_lo, r_dz, t_hi[i], t_lo[i], t_dz[i]);
         end
         checks++;
         if (held !== 1'b1 || after_ok !== 1'b1) begin
            failures++;
            $display("FAIL directed%0d_hold: got held=%b after_ok=%b expected 1/1", i, held, after_ok);
         end
      end
   endtask

   function automatic logic [W-1:0] pick_operand(input int kind);
      case (kind)
         0: return '0;
         1: return '1;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(1, 20));
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      int             lat;
      logic [1:0]     o;
      logic [W-1:0]   x, y, r_hi, r_lo;
      logic           r_dz, held, after_ok, exp_dz;
      logic [2*W-1:0] exp;
      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom_range(0, 3));
         x = pick_operand($urandom_range(0, 9));
         y = pick_operand($urandom_range(0, 9));
         exp_q.push_back(ref_model(o, x, y));
         exp_dz = o[1] && (y == '0);
         issue_op(o, x, y, lat, r_hi, r_lo, r_dz, held, after_ok);
         exp = exp_q.pop_front();
         checks++;
         if (lat != W || held !== 1'b1 || after_ok !== 1'b1) begin
            failures++;
            $display("FAIL random%0d_timing: got lat=%0d held=%b after_ok=%b expected %0d/1/1",
                     i, lat, held, after_ok, W);
         end
         checks++;
         if ({r_hi, r_lo} !== exp || r_dz !== exp_dz) begin
            failures++;
            $display("FAIL random%0d_result: op=%0d a=%h b=%h got hi=%h lo=%h dz=%b expected hi=%h lo=%h dz=%b",
                     i, o, x, y, r_hi, r_lo, r_dz, exp[2*W-1:W], exp[W-1:0], exp_dz);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0]   hi0, lo0;
      logic [2*W-1:0] exp;
      int             lat;
      logic           held;
      exp = ref_model(2'b01, 32'hFFFF_FF00, 32'h0000_1235);
      @(negedge clock);
      op = 2'b01; a = 32'hFFFF_FF00; b = 32'h0000_1235; start = 1'b1;
      hi0 = hi; lo0 = lo;
      @(posedge clock); #1;
      start = 1'b0;
      lat = -1;
      held = 1'b1;
      for (int n = 1; n <= W + 8; n++) begin
         @(posedge clock); #1;
         if (done) begin
            lat = n;
            break;
         end
         if (hi !== hi0 || lo !== lo0) held = 1'b0;
         if (n == 5) begin
            start = 1'b1; op = 2'b10; a = 32'h0000_0077; b = 32'h0000_0003;
            wr_lo = 1'b1; wdata = 32'hA5A5_5A5A;
         end else if (n == 7) begin
            idle_inputs();
         end
      end
      checks++;
      if (lat != W || held !== 1'b1) begin
         failures++;
         $display("FAIL ignore_start_timing: got lat=%0d held=%b expected %0d/1", lat, held, W);
      end
      checks++;
      if ({hi, lo} !== exp) begin
         failures++;
         $display("FAIL ignore_start_result: got hi=%h lo=%h expected hi=%h lo=%h",
                  hi, lo, exp[2*W-1:W], exp[W-1:0]);
      end
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_no_queue: got busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_direct_write();
      logic [W-1:0]   w1, w2, w3, lo0;
      logic [2*W-1:0] exp;
      int             lat;
      w1 = $urandom; w2 = $urandom; w3 = $urandom;
      @(negedge clock);
      wr_hi = 1'b1; wdata = w1;
      @(negedge clock);
      idle_inputs();
      lo0 = lo;
      checks++;
      if (hi !== w1 || lo !== lo0) begin
         failures++;
         $display("FAIL write_hi: got hi=%h expected %h", hi, w1);
      end
      wr_lo = 1'b1; wdata = w2;
      @(negedge clock);
      idle_inputs();
      checks++;
      if (lo !== w2 || hi !== w1) begin
         failures++;
         $display("FAIL write_lo: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, w1, w2);
      end
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = w3;
      @(negedge clock);
      idle_inputs();
      checks++;
      if (hi !== w3 || lo !== w3) begin
         failures++;
         $display("FAIL write_both: got hi=%h lo=%h expected %h", hi, lo, w3);
      end
      // A write on the accepting edge must be dropped
      exp = ref_model(2'b10, 32'd1000, 32'd7);
      op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = ~w3;
      @(posedge clock); #1;
      idle_inputs();
      checks++;
      if (hi !== w3 || lo !== w3 || busy !== 1'b1) begin
         failures++;
         $display("FAIL write_on_start: got hi=%h lo=%h busy=%b expected hi=lo=%h busy=1",
                  hi, lo, busy, w3);
      end
      lat = -1;
      for (int n = 1; n <= W + 8; n++) begin
         @(posedge clock); #1;
         if (done) begin
            lat = n;
            break;
         end
      end
      checks++;
      if (lat != W || {hi, lo} !== exp) begin
         failures++;
         $display("FAIL write_on_start_result: got lat=%0d hi=%h lo=%h expected %0d hi=%h lo=%h",
                  lat, hi, lo, W, exp[2*W-1:W], exp[W-1:0]);
      end
   endtask

   task automatic test_reset_abort();
      logic           saw_done;
      int             lat;
      logic [W-1:0]   r_hi, r_lo;
      logic           r_dz, held, after_ok;
      logic [2*W-1:0] exp;
      @(negedge clock);
      op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
         failures++;
         $display("FAIL reset_abort_state: got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0",
                  busy, done, hi, lo);
      end
      saw_done = 1'b0;
      for (int n = 0; n < W + 4; n++) begin
         @(posedge clock); #1;
         if (done || busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort_no_done: got activity=%b expected 0", saw_done);
      end
      exp = ref_model(2'b11, 32'hFFFF_8000, 32'h0000_0123);
      issue_op(2'b11, 32'hFFFF_8000, 32'h0000_0123, lat, r_hi, r_lo, r_dz, held, after_ok);
      checks++;
      if (lat != W || {r_hi, r_lo} !== exp || r_dz !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort_restart: got lat=%0d hi=%h lo=%h dz=%b expected %0d hi=%h lo=%h dz=0",
                  lat, r_hi, r_lo, r_dz, W, exp[2*W-1:W], exp[W-1:0]);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      op = 2'b00; a = '0; b = '0; wdata = '0;
      test_reset();
      test_directed();
      test_ignore_start();
      test_direct_write();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
